// File: rtl/ibex_register_file_mp.sv
// Flop-based register file with configurable read ports, two prioritised write ports,
// optional write-to-read bypass, per-byte parity and an x0 shadow for dummy instructions.
module ibex_register_file_mp #(
    parameter bit          RV32E             = 1'b0,
    parameter int unsigned DataWidth         = 32,
    parameter int unsigned NumReadPorts      = 2,
    parameter bit          WriteBypass       = 1'b0,
    parameter bit          ParityEnable      = 1'b0,
    parameter bit          DummyInstructions = 1'b0
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              dummy_instr_id_i,
    input  logic [NumReadPorts-1:0]           re_i,
    input  logic [5*NumReadPorts-1:0]         raddr_i,
    output logic [DataWidth*NumReadPorts-1:0] rdata_o,
    input  logic                              we_a_i,
    input  logic [4:0]                        waddr_a_i,
    input  logic [DataWidth-1:0]              wdata_a_i,
    input  logic                              we_b_i,
    input  logic [4:0]                        waddr_b_i,
    input  logic [DataWidth-1:0]              wdata_b_i,
    input  logic                              err_inject_i,
    output logic                              err_o,
    output logic [1:0]                        err_port_o
);

    localparam int unsigned AddrWidth = RV32E ? 4 : 5;
    localparam int unsigned NumWords  = 2 ** AddrWidth;
    localparam int unsigned NumBytes  = DataWidth / 8;

    typedef logic [DataWidth-1:0] word_t;
    typedef logic [NumBytes-1:0]  par_t;
    typedef logic [AddrWidth-1:0] addr_t;

    function automatic par_t calc_parity(input word_t d);
        par_t p;
        for (int k = 0; k < int'(NumBytes); k++) begin
            p[k] = ^d[8*k +: 8];
        end
        return p;
    endfunction

    word_t rf_q  [NumWords];
    par_t  par_q [NumWords];
    word_t x0_shadow_q;

    addr_t waddr_a;
    addr_t waddr_b;
    par_t  wpar_a;
    par_t  wpar_b;

    logic  unused_addr_bits;

    assign waddr_a = waddr_a_i[AddrWidth-1:0];
    assign waddr_b = waddr_b_i[AddrWidth-1:0];
    // Inverting bit 0 lets software plant a detectable fault on a port-A write.
    assign wpar_a  = calc_parity(wdata_a_i) ^ par_t'(err_inject_i);
    assign wpar_b  = calc_parity(wdata_b_i);

    assign unused_addr_bits = ^{raddr_i, waddr_a_i, waddr_b_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NumWords); i++) begin
                rf_q[i]  <= '0;
                par_q[i] <= '0;
            end
            x0_shadow_q <= '0;
        end else begin
            for (int i = 1; i < int'(NumWords); i++) begin
                if (we_b_i && (waddr_b == addr_t'(i))) begin
                    rf_q[i]  <= wdata_b_i;
                    par_q[i] <= wpar_b;
                end else if (we_a_i && (waddr_a == addr_t'(i))) begin
                    rf_q[i]  <= wdata_a_i;
                    par_q[i] <= wpar_a;
                end
            end
            if (DummyInstructions && dummy_instr_id_i) begin
                if (we_b_i && (waddr_b == '0)) begin
                    x0_shadow_q <= wdata_b_i;
                end else if (we_a_i && (waddr_a == '0)) begin
                    x0_shadow_q <= wdata_a_i;
                end
            end
        end
    end

    logic [NumReadPorts-1:0] chk_fail;

    for (genvar p = 0; p < int'(NumReadPorts); p++) begin : g_rd
        addr_t ra;
        logic  hit_a;
        logic  hit_b;
        word_t stored;

        assign ra     = raddr_i[5*p +: AddrWidth];
        assign hit_b  = WriteBypass && we_b_i && (waddr_b == ra) && (ra != '0);
        assign hit_a  = WriteBypass && we_a_i && (waddr_a == ra) && (ra != '0);
        assign stored = (ra == '0) ?
                        ((DummyInstructions && dummy_instr_id_i) ? x0_shadow_q : '0) :
                        rf_q[ra];

        assign rdata_o[DataWidth*p +: DataWidth] = hit_b ? wdata_b_i :
                                                   hit_a ? wdata_a_i : stored;

        // Bypassed reads never touched the array, so there is nothing to check.
        assign chk_fail[p] = ParityEnable && re_i[p] && (ra != '0) && !hit_a && !hit_b &&
                             (calc_parity(rf_q[ra]) != par_q[ra]);
    end

    logic [1:0] err_port_d;
    logic       err_q;
    logic [1:0] err_port_q;

    always_comb begin
        err_port_d = '0;
        for (int p = int'(NumReadPorts) - 1; p >= 0; p--) begin
            if (chk_fail[p]) begin
                err_port_d = 2'(p);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q      <= 1'b0;
            err_port_q <= '0;
        end else begin
            err_q      <= |chk_fail;
            err_port_q <= err_port_d;
        end
    end

    assign err_o      = ParityEnable ? err_q : 1'b0;
    assign err_port_o = ParityEnable ? err_port_q : 2'b00;

endmodule

// File: doc/ibex_register_file_mp.md
Name: ibex_register_file_mp

Overview:
Multi-port, flop-based general-purpose register file, the parametrised successor of the single-write latch register file. It provides a configurable number of read ports, two write ports with fixed priority, and optional same-cycle write-to-read bypass. It can also store per-byte parity, with a registered error report. It sits in the ID/WB boundary of the core and serves dual-issue or early-writeback pipelines.

Parameters:
RV32E, 0, 1 = 16 registers (4-bit address, bit 4 of every address ignored); 0 = 32 registers.
DataWidth, 32, register width; must be a multiple of 8.
NumReadPorts, 2, number of read ports, 1..4.
WriteBypass, 0, 1 = a read returns the data being written in the same cycle.
ParityEnable, 0, 1 = store one even-parity bit per byte and check it on qualified reads.
DummyInstructions, 0, 1 = x0 is backed by a writable shadow register for dummy instructions.

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
dummy_instr_id_i  input  1  current ID instruction is a dummy instruction
re_i  input  NumReadPorts  per-port read-valid; qualifies the parity check only
raddr_i  input  5*NumReadPorts  read addresses; port p uses bits [5p+4:5p]
rdata_o  output  DataWidth*NumReadPorts  read data; port p uses its DataWidth slice
we_a_i  input  1  write enable, port A
waddr_a_i  input  5  write address, port A
wdata_a_i  input  DataWidth  write data, port A
we_b_i  input  1  write enable, port B (higher priority)
waddr_b_i  input  5  write address, port B
wdata_b_i  input  DataWidth  write data, port B
err_inject_i  input  1  when set with we_a_i, inverts the stored parity bit of byte 0 for the port-A write
err_o  output  1  registered parity error pulse
err_port_o  output  2  lowest-numbered port that failed the check; valid while err_o is high

Behaviour:
- Reset (asynchronous, rst_ni low): every register, its parity bits, the x0 shadow, err_o and err_port_o are cleared to 0. All-zero data with zero parity is consistent.
- Address width: ADDR_WIDTH = RV32E ? 4 : 5. Upper address bits are truncated on every port.
- Read path: combinational, zero latency.
  - Address 0 returns 0.
  - With DummyInstructions=1 and dummy_instr_id_i=1, address 0 returns the x0 shadow instead.
- Write path: takes effect at posedge clk_i, so the new value is visible on the next cycle.
  - A write to address 0 is dropped, except when DummyInstructions=1 and dummy_instr_id_i=1; the write then updates the x0 shadow.
  - If both ports write the same address in one cycle, port B's data (and B's parity) is stored; A is discarded.
  - Writes to different addresses both complete.
- Bypass (WriteBypass=1):
  - If a read address equals an enabled write address in the same cycle, rdata returns that write data. When A and B target the same address, B wins.
  - Address 0 is never bypassed.
  - With WriteBypass=0, a same-cycle read returns the old stored value.
- Parity (ParityEnable=1):
  - On write, the stored parity bit k is the XOR of byte k of the written data; err_inject_i inverts bit 0 for port-A writes.
  - On each cycle, for each port p with re_i[p]=1 and address != 0 and no bypass hit, the stored bytes are recomputed and compared with the stored parity.
  - Any mismatch sets err_o=1 on the following cycle for exactly one cycle per failing read cycle. err_port_o takes the lowest failing port.
  - Otherwise err_o=0. Consecutive failing reads give consecutive pulses.
- ParityEnable=0: err_o and err_port_o are tied to 0; err_inject_i and re_i are unused.
- Reset mid-operation: state clears immediately, independent of the clock. A write or error pending on the same edge is lost.
- No handshake; every request completes in the cycle it is presented.

Test Plan:
- Reset, then read all addresses on all ports -> all rdata = 0x00000000, err_o=0.
- Write A x5=0xDEADBEEF and B x7=0x12345678 in one cycle, then read x5/x7 on ports 0/1 the next cycle -> 0xDEADBEEF and 0x12345678.
- A and B both write x3 (A=0x1111, B=0x2222), then read x3 -> 0x2222.
- WriteBypass=1: write A x9=0xCAFEF00D while port 1 reads x9 in the same cycle -> rdata 0xCAFEF00D in that cycle. Repeat with WriteBypass=0 -> the old value 0 is returned.
- Write x0=0xFFFFFFFF with dummy_instr_id_i=0 -> x0 reads 0. With DummyInstructions=1 and dummy_instr_id_i=1, the same write followed by a read with dummy=1 -> 0xFFFFFFFF; the same read with dummy=0 -> 0.
- ParityEnable=1: write x4 with err_inject_i=1, then read x4 on port 1 with re_i=0b10 -> err_o=1 and err_port_o=1 one cycle later, 0 in the cycle after. A read with re_i=0 -> no error.
